// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with performance counters and a stall watchdog
module pipe_ctrl #(
    parameter int STAGES  = 6,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    input  logic              cnt_clr,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [31:0]       new_pc_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [TW-1:0]     run_q, run_d;
    logic              timeout_q;
    logic [STAGES-1:0] therm;

    // A stalled stage also holds every stage upstream of it, down to the PC.
    always_comb begin
        therm = '0;
        for (int i = 0; i < STAGES; i++) therm[i] = |(stallreq >> i);
        stall = (state_q == FLUSH && !rst) ? '0 : therm;
        state_d = flush_req ? FLUSH : (state_q == FLUSH) ? RUN : (|stallreq) ? STALL : RUN;
        stall_cnt_d = cnt_clr ? '0 : (|stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = cnt_clr ? '0 : (flush_req && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
        run_d = (state_d != STALL) ? '0 : (run_q == TW'(TIMEOUT)) ? run_q : run_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            if (flush_req) new_pc_q <= flush_pc;
            if (run_d == TW'(TIMEOUT)) timeout_q <= 1'b1;
        end
    end

    assign flush         = (state_q == FLUSH);
    assign new_pc        = new_pc_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus randomized run against a behavioural model, two parameterizations
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst, fr, clr;
    logic [5:0] sr;
    logic [31:0] pc;
    logic [5:0] st0, st1;
    logic fl0, fl1, to0, to1;
    logic [31:0] np0, np1, sc0, fc0;
    logic [2:0] sc1, fc1;
    int n_chk = 0, n_pass = 0;

    logic m_fl, m_to0, m_to1;
    logic [31:0] m_npc;
    longint m_sc, m_fc;
    int m_run;

    always #5 clk = ~clk;

    pipe_ctrl u0 (.clk(clk), .rst(rst), .stallreq(sr), .flush_req(fr), .flush_pc(pc), .cnt_clr(clr),
                  .stall(st0), .flush(fl0), .new_pc(np0), .stall_cnt(sc0), .flush_cnt(fc0), .stall_timeout(to0));

    pipe_ctrl #(.STAGES(6), .CNT_W(3), .TIMEOUT(4)) u1 (
        .clk(clk), .rst(rst), .stallreq(sr), .flush_req(fr), .flush_pc(pc), .cnt_clr(clr),
        .stall(st1), .flush(fl1), .new_pc(np1), .stall_cnt(sc1), .flush_cnt(fc1), .stall_timeout(to1));

    typedef struct {
        logic rst; logic [5:0] sr; logic fr; logic [31:0] pc; logic clr;
        logic [5:0] e_stall; logic e_flush; logic [31:0] e_npc; int e_s0; int e_f0; int e_s1; logic e_to1;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [5:0] therm(input logic [5:0] r);
        int h = -1;
        longint m;
        for (int i = 0; i < 6; i++) if (r[i]) h = i;
        m = (h < 0) ? 0 : ((64'd1 << (h + 1)) - 1);
        return m[5:0];
    endfunction

    function automatic longint sat7(input longint v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input logic r, input logic [5:0] s, input logic f, input logic [31:0] p, input logic c);
        rst = r; sr = s; fr = f; pc = p; clr = c;
        #3;
    endtask

    task automatic check_model();
        logic [5:0] e_st;
        e_st = (m_fl && !rst) ? 6'd0 : therm(sr);
        chk("stall0", st0, e_st);
        chk("stall1", st1, e_st);
        chk("flush0", fl0, m_fl);
        chk("flush1", fl1, m_fl);
        chk("new_pc0", np0, m_npc);
        chk("new_pc1", np1, m_npc);
        chk("stall_cnt0", sc0, m_sc);
        chk("flush_cnt0", fc0, m_fc);
        chk("stall_cnt1", sc1, sat7(m_sc));
        chk("flush_cnt1", fc1, sat7(m_fc));
        chk("timeout0", to0, m_to0);
        chk("timeout1", to1, m_to1);
    endtask

    task automatic advance();
        logic [5:0] e_st;
        logic stalling;
        e_st = (m_fl && !rst) ? 6'd0 : therm(sr);
        @(posedge clk);
        if (rst) begin
            m_fl = 0; m_npc = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to0 = 0; m_to1 = 0;
        end else begin
            if (clr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                m_sc += (e_st != 0) ? 1 : 0;
                m_fc += fr ? 1 : 0;
            end
            stalling = !fr && (sr != 0) && !m_fl;
            m_run = stalling ? m_run + 1 : 0;
            if (fr) m_npc = pc;
            m_fl = fr;
            if (m_run >= 1023) m_to0 = 1;
            if (m_run >= 4) m_to1 = 1;
        end
        #1;
    endtask

    initial begin
        m_fl = 0; m_npc = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to0 = 0; m_to1 = 0;
        tbl.push_back('{1, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{0, 6'b000100, 0, 32'h0,        0, 6'b000111, 0, 32'h0,        0, 0, 0, 0});
        tbl.push_back('{0, 6'b000100, 0, 32'h0,        0, 6'b000111, 0, 32'h0,        1, 0, 1, 0});
        tbl.push_back('{0, 6'b000100, 0, 32'h0,        0, 6'b000111, 0, 32'h0,        2, 0, 2, 0});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h0,        3, 0, 3, 0});
        tbl.push_back('{0, 6'b001000, 1, 32'hBFC00380, 0, 6'b001111, 0, 32'h0,        3, 0, 3, 0});
        tbl.push_back('{0, 6'b001000, 0, 32'h0,        0, 6'b000000, 1, 32'hBFC00380, 4, 1, 4, 0});
        tbl.push_back('{0, 6'b000000, 1, 32'h100,      0, 6'b000000, 0, 32'hBFC00380, 4, 1, 4, 0});
        tbl.push_back('{0, 6'b000000, 1, 32'h200,      0, 6'b000000, 1, 32'h100,      4, 2, 4, 0});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 1, 32'h200,      4, 3, 4, 0});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h200,      4, 3, 4, 0});
        tbl.push_back('{0, 6'b100000, 0, 32'h0,        0, 6'b111111, 0, 32'h200,      4, 3, 4, 0});
        tbl.push_back('{0, 6'b100000, 0, 32'h0,        0, 6'b111111, 0, 32'h200,      5, 3, 5, 0});
        tbl.push_back('{0, 6'b100000, 0, 32'h0,        0, 6'b111111, 0, 32'h200,      6, 3, 6, 0});
        tbl.push_back('{0, 6'b100000, 0, 32'h0,        0, 6'b111111, 0, 32'h200,      7, 3, 7, 0});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h200,      8, 3, 7, 1});
        tbl.push_back('{0, 6'b000001, 0, 32'h0,        1, 6'b000001, 0, 32'h200,      8, 3, 7, 1});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h200,      0, 0, 0, 1});
        tbl.push_back('{0, 6'b000010, 1, 32'h1234,     0, 6'b000011, 0, 32'h200,      0, 0, 0, 1});
        tbl.push_back('{1, 6'b000010, 1, 32'h5678,     0, 6'b000011, 1, 32'h1234,     1, 1, 1, 1});
        tbl.push_back('{0, 6'b000000, 0, 32'h0,        0, 6'b000000, 0, 32'h0,        0, 0, 0, 0});
        for (int k = 0; k < 2; k++) begin
            apply(1, 6'b0, 0, 32'h0, 0);
            advance();
        end
        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].sr, tbl[k].fr, tbl[k].pc, tbl[k].clr);
            check_model();
            chk($sformatf("tbl%0d_stall", k), st0, tbl[k].e_stall);
            chk($sformatf("tbl%0d_flush", k), fl0, tbl[k].e_flush);
            chk($sformatf("tbl%0d_new_pc", k), np0, tbl[k].e_npc);
            chk($sformatf("tbl%0d_stall_cnt", k), sc0, tbl[k].e_s0);
            chk($sformatf("tbl%0d_flush_cnt", k), fc0, tbl[k].e_f0);
            chk($sformatf("tbl%0d_stall_cnt_w3", k), sc1, tbl[k].e_s1);
            chk($sformatf("tbl%0d_timeout_t4", k), to1, tbl[k].e_to1);
            advance();
        end
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] s;
            s = sr;
            if ($urandom_range(3) == 0) s = ($urandom_range(1) == 1) ? 6'($urandom) : 6'd0;
            apply($urandom_range(99) == 0, s, $urandom_range(6) == 0, $urandom, $urandom_range(39) == 0);
            check_model();
            advance();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
